// File: rtl/ula_seq.sv
// rtl/ula_seq.sv - registered ALU with start/done handshake and iterative multiply
//
// Purpose: executes add/sub/and-test/barrel-pass/or/slt in a single cycle, and
// a shift-add multiply over WIDTH cycles. Result and flags are registered and
// change only on the edge that raises done.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset
//   start      in   request, sampled only while busy is low
//   OPcode     in   000 add, 001 sub, 010 and-test, 011 barrel pass, 100 or,
//                   101 slt (signed), 110 mul (low WIDTH bits), 111 reserved
//   in_1       in   operand A
//   in_2       in   operand B
//   barrel_out in   barrel shifter output, used by 011
//   result     out  registered result
//   zero       out  result == 0
//   carry      out  add carry-out / sub borrow, else 0
//   overflow   out  signed overflow (add/sub), high product bits nonzero (mul)
//   negative   out  result MSB
//   busy       out  multiply in progress
//   done       out  one-cycle pulse when result/flags update
module ula_seq #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       OPcode,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [WIDTH-1:0] barrel_out,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               overflow_q, overflow_d;
  logic               negative_q, negative_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               is_mul;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [2*WIDTH-1:0] acc_next;

  assign is_mul   = (OPcode == 3'b110) && MUL_EN;
  assign sum_ext  = {1'b0, in_1} + {1'b0, in_2};
  // The extra MSB of the difference is the unsigned borrow (in_1 < in_2).
  assign diff_ext = {1'b0, in_1} - {1'b0, in_2};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (OPcode)
      3'b000: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (in_1[WIDTH-1] == in_2[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != in_1[WIDTH-1]);
      end
      3'b001: begin
        alu_res = diff_ext[WIDTH-1:0];
        alu_c   = diff_ext[WIDTH];
        alu_v   = (in_1[WIDTH-1] != in_2[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != in_1[WIDTH-1]);
      end
      3'b010:  alu_res = {{(WIDTH-1){1'b0}}, |(in_1 & in_2)};
      3'b011:  alu_res = barrel_out;
      3'b100:  alu_res = in_1 | in_2;
      3'b101:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_1) < $signed(in_2))};
      default: alu_res = '0;  // 110 without multiplier, 111 reserved
    endcase
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    negative_d = negative_q;
    done_d     = 1'b0;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    acc_next   = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_mul) begin
            mcand_d  = {{WIDTH{1'b0}}, in_1};
            mplier_d = in_2;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL;
          end else begin
            result_d   = alu_res;
            zero_d     = (alu_res == '0);
            carry_d    = alu_c;
            overflow_d = alu_v;
            negative_d = alu_res[WIDTH-1];
            done_d     = 1'b1;
          end
        end
      end
      MUL: begin
        // Multiplicand is kept pre-shifted so iteration k adds in_1 << k.
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d   = acc_next[WIDTH-1:0];
          zero_d     = (acc_next[WIDTH-1:0] == '0);
          carry_d    = 1'b0;
          overflow_d = |acc_next[2*WIDTH-1:WIDTH];
          negative_d = acc_next[WIDTH-1];
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      result_q   <= '0;
      zero_q     <= 1'b1;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      negative_q <= 1'b0;
      done_q     <= 1'b0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      negative_q <= negative_d;
      done_q     <= done_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign negative = negative_q;
  assign done     = done_q;
  assign busy     = (state_q == MUL);

endmodule

// File: tb/tb_ula_seq.sv
// tb/tb_ula_seq.sv - self-checking bench for ula_seq
module tb_ula_seq;
  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   OPcode;
  logic [W-1:0] in_1, in_2, barrel_out;
  logic [W-1:0] result;
  logic         zero, carry, overflow, negative, busy, done;

  int checks   = 0;
  int failures = 0;

  localparam logic [19:0] RESET_VEC = {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};

  always #5 clock = ~clock;

  ula_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .start(start), .OPcode(OPcode),
    .in_1(in_1), .in_2(in_2), .barrel_out(barrel_out),
    .result(result), .zero(zero), .carry(carry), .overflow(overflow),
    .negative(negative), .busy(busy), .done(done)
  );

  // Reference: {result, zero, carry, overflow, negative} from plain integer arithmetic.
  function automatic logic [19:0] model(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic [15:0] bar);
    longint ua, ub, sa, sb, full;
    logic [15:0] r;
    bit c, v;
    ua = a; ub = b;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    r = 16'h0; c = 0; v = 0;
    case (op)
      3'd0: begin
        full = ua + ub; r = 16'(full % 65536); c = (full > 65535);
        v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
      end
      3'd1: begin
        full = ua - ub; r = 16'((full + 65536) % 65536); c = (ua < ub);
        v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
      end
      3'd2: r = ((a & b) != 0) ? 16'd1 : 16'd0;
      3'd3: r = bar;
      3'd4: r = a | b;
      3'd5: r = (sa < sb) ? 16'd1 : 16'd0;
      3'd6: begin
        full = ua * ub; r = 16'(full % 65536); v = (full > 65535);
      end
      default: r = 16'h0;
    endcase
    return {r, (r == 16'h0), c, v, r[15]};
  endfunction

  // Issues one op and observes it: got = outputs on the done cycle, lat = cycles from the
  // start edge to done (1 = cycle right after the edge), bcnt = busy cycles before done,
  // dones = done pulses including 3 idle cycles after, both = busy&done ever seen together.
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] bar, input bit inject,
                        output logic [19:0] got, output int lat, output int bcnt,
                        output int dones, output bit both);
    @(negedge clock);
    OPcode = op; in_1 = a; in_2 = b; barrel_out = bar; start = 1'b1;
    @(negedge clock);
    start = 1'b0; lat = 1; bcnt = 0; dones = 0; both = 0; got = 'x;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      start = inject && (lat == 3);
      if (start) OPcode = 3'b000;
      in_1 = 16'($urandom); in_2 = 16'($urandom);
      @(negedge clock);
      lat++;
    end
    start = 1'b0;
    if (done) begin
      dones = 1;
      got = {result, zero, carry, overflow, negative};
      both = busy;
    end
    repeat (3) begin
      @(negedge clock);
      if (done) dones++;
      if (busy && done) both = 1;
    end
  endtask

  task automatic test_reset();
    logic [19:0] got; int lat, bcnt, dones, nd; bit both;
    reset = 1'b1; start = 1'b0; OPcode = 3'd0; in_1 = '0; in_2 = '0; barrel_out = '0;
    repeat (3) @(negedge clock);
    checks++;
    if ({result, zero, carry, overflow, negative} !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", {result, zero, carry, overflow, negative}, RESET_VEC);
    end
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done});
    end
    reset = 1'b0;
    run_op(3'd0, 16'h1234, 16'h0001, 16'h0, 0, got, lat, bcnt, dones, both);
    checks++;
    if (got !== model(3'd0, 16'h1234, 16'h0001, 16'h0)) begin
      failures++; $display("FAIL pre_reset_add got=%h exp=%h", got, model(3'd0, 16'h1234, 16'h0001, 16'h0));
    end
    // Multiply abandoned by a 2-cycle reset.
    @(negedge clock);
    OPcode = 3'b110; in_1 = 16'd300; in_2 = 16'd300; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL mid_mul_busy got=%b exp=1", busy); end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({result, zero, carry, overflow, negative, busy, done} !== {RESET_VEC, 2'b00}) begin
      failures++;
      $display("FAIL reset_mid_mul got=%h exp=%h",
               {result, zero, carry, overflow, negative, busy, done}, {RESET_VEC, 2'b00});
    end
    reset = 1'b0;
    nd = 0;
    repeat (25) begin @(negedge clock); if (done || busy) nd++; end
    checks++;
    if (nd !== 0) begin failures++; $display("FAIL reset_no_done got=%0d exp=0", nd); end
  endtask

  task automatic test_add();
    logic [19:0] got; int lat, bcnt, dones; bit both;
    run_op(3'd0, 16'hFFFF, 16'h0001, 16'h0, 0, got, lat, bcnt, dones, both);
    checks++;
    if (got !== {16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      failures++; $display("FAIL add_wrap got=%h exp=%h", got, {16'h0000, 4'b1100});
    end
    checks++;
    if (lat !== 1 || dones !== 1) begin
      failures++; $display("FAIL add_latency got lat=%0d dones=%0d exp lat=1 dones=1", lat, dones);
    end
  endtask

  task automatic test_sub();
    logic [19:0] got; int lat, bcnt, dones; bit both;
    run_op(3'd1, 16'h8000, 16'h0001, 16'h0, 0, got, lat, bcnt, dones, both);
    checks++;
    if (got !== {16'h7FFF, 4'b0010}) begin
      failures++; $display("FAIL sub_overflow got=%h exp=%h", got, {16'h7FFF, 4'b0010});
    end
    run_op(3'd1, 16'h0003, 16'h0005, 16'h0, 0, got, lat, bcnt, dones, both);
    checks++;
    if (got !== {16'hFFFE, 4'b0101}) begin
      failures++; $display("FAIL sub_borrow got=%h exp=%h", got, {16'hFFFE, 4'b0101});
    end
  endtask

  task automatic test_mul();
    logic [19:0] got; int lat, bcnt, dones; bit both;
    run_op(3'd6, 16'd300, 16'd300, 16'h0, 0, got, lat, bcnt, dones, both);
    checks++;
    if (got !== {16'h5F90, 4'b0010}) begin
      failures++; $display("FAIL mul_300x300 got=%h exp=%h", got, {16'h5F90, 4'b0010});
    end
    checks++;
    if (lat !== 17 || bcnt !== 16 || dones !== 1 || both !== 0) begin
      failures++;
      $display("FAIL mul_timing got lat=%0d busy=%0d dones=%0d both=%0d exp 17 16 1 0",
               lat, bcnt, dones, both);
    end
    run_op(3'd6, 16'd7, 16'd6, 16'h0, 0, got, lat, bcnt, dones, both);
    checks++;
    if (got !== {16'd42, 4'b0000}) begin
      failures++; $display("FAIL mul_7x6 got=%h exp=%h", got, {16'd42, 4'b0000});
    end
  endtask

  task automatic test_handshake();
    logic [19:0] got; int lat, bcnt, dones; bit both;
    run_op(3'd6, 16'd1234, 16'd5, 16'h0, 1, got, lat, bcnt, dones, both);
    checks++;
    if (got !== model(3'd6, 16'd1234, 16'd5, 16'h0)) begin
      failures++; $display("FAIL handshake_result got=%h exp=%h", got, model(3'd6, 16'd1234, 16'd5, 16'h0));
    end
    checks++;
    if (dones !== 1 || lat !== 17 || both !== 0) begin
      failures++;
      $display("FAIL handshake_ignore_start got dones=%0d lat=%0d both=%0d exp 1 17 0", dones, lat, both);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops [4] = '{3'd0, 3'd4, 3'd5, 3'd3};
    logic [15:0] as  [4] = '{16'h1234, 16'h00F0, 16'h0005, 16'h0000};
    logic [15:0] bs  [4] = '{16'h1111, 16'h0F0F, 16'hFFF0, 16'h0000};
    logic [15:0] bar = 16'hBEEF;
    logic [19:0] exp;
    @(negedge clock);
    OPcode = ops[0]; in_1 = as[0]; in_2 = bs[0]; barrel_out = bar; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      exp = model(ops[i], as[i], bs[i], bar);
      checks++;
      if (done !== 1'b1 || {result, zero, carry, overflow, negative} !== exp) begin
        failures++;
        $display("FAIL back_to_back_%0d got done=%b out=%h exp done=1 out=%h",
                 i, done, {result, zero, carry, overflow, negative}, exp);
      end
      if (i < 3) begin
        OPcode = ops[i+1]; in_1 = as[i+1]; in_2 = bs[i+1];
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL back_to_back_end got=%b exp=0", done); end
  endtask

  task automatic test_misc();
    logic [19:0] got; int lat, bcnt, dones; bit both;
    run_op(3'd2, 16'h00F0, 16'h0F00, 16'h0, 0, got, lat, bcnt, dones, both);
    checks++;
    if (got !== {16'h0000, 4'b1000}) begin
      failures++; $display("FAIL and_test got=%h exp=%h", got, {16'h0000, 4'b1000});
    end
    run_op(3'd5, 16'hFFFF, 16'h0001, 16'h0, 0, got, lat, bcnt, dones, both);
    checks++;
    if (got !== {16'h0001, 4'b0000}) begin
      failures++; $display("FAIL slt_signed got=%h exp=%h", got, {16'h0001, 4'b0000});
    end
    run_op(3'd7, 16'h1234, 16'h5678, 16'hFFFF, 0, got, lat, bcnt, dones, both);
    checks++;
    if (got !== {16'h0000, 4'b1000} || lat !== 1) begin
      failures++; $display("FAIL reserved_op got=%h lat=%0d exp=%h lat=1", got, lat, {16'h0000, 4'b1000});
    end
  endtask

  task automatic test_random();
    logic [19:0] got, exp; int lat, bcnt, dones, exp_lat; bit both;
    logic [2:0] op; logic [15:0] a, b, bar;
    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = (i % 4 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      b   = (i % 4 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      bar = 16'($urandom);
      exp = model(op, a, b, bar);
      exp_lat = (op == 3'd6) ? 17 : 1;
      run_op(op, a, b, bar, 0, got, lat, bcnt, dones, both);
      checks++;
      if (got !== exp || lat !== exp_lat || dones !== 1 || both !== 0) begin
        failures++;
        $display("FAIL random_%0d op=%0d a=%h b=%h got=%h lat=%0d dones=%0d both=%0d exp=%h lat=%0d",
                 i, op, a, b, got, lat, dones, both, exp, exp_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_handshake();
    test_back_to_back();
    test_misc();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
